// File: rtl/iomem_initiator_if.sv
// Command, response and iomem bus signals of the iomem initiator, bundled as one interface.
// master is the initiator's view; slave is the view of whoever sits on the other ends.
interface iomem_initiator_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        input  iomem_ready, iomem_rdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        output iomem_ready, iomem_rdata
    );
endinterface

// File: rtl/iomem_initiator.sv
// Single-outstanding bus master for the iomem peripheral bus (command in, response out).
// Define IOMEM_INITIATOR_TIMEOUT_EN to abort requests left unanswered for TIMEOUT_CYCLES.
module iomem_initiator #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 16
) (
    input  logic              clk,
    input  logic              resetn,
    iomem_initiator_if.master bus,
    output logic              busy,
    output logic [CNT_W-1:0]  txn_count
);
    // state | meaning
    // IDLE  | cmd_ready high, waiting for a command
    // BUS   | iomem_valid high, waiting for iomem_ready (or timeout)
    // RESP  | rsp_valid high, waiting for rsp_ready
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("iomem_initiator: TIMEOUT_CYCLES must be within 1..65535");
    end

    state_t           state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       wstrb_q, wstrb_d;
    logic             write_q, write_d;
    logic             req_q, req_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [31:0]      rsp_rdata_q, rsp_rdata_d;
    logic [CNT_W-1:0] txn_q, txn_d;

`ifdef IOMEM_INITIATOR_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_TC = 16'(TIMEOUT_CYCLES);
    logic             rsp_err_q, rsp_err_d;
    logic [15:0]      wait_q, wait_d;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            write_q     <= 1'b0;
            req_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            txn_q       <= '0;
`ifdef IOMEM_INITIATOR_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
            wait_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            write_q     <= write_d;
            req_q       <= req_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            txn_q       <= txn_d;
`ifdef IOMEM_INITIATOR_TIMEOUT_EN
            rsp_err_q   <= rsp_err_d;
            wait_q      <= wait_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        write_d     = write_q;
        req_d       = req_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        txn_d       = txn_q;
`ifdef IOMEM_INITIATOR_TIMEOUT_EN
        rsp_err_d   = rsp_err_q;
        wait_d      = wait_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    addr_d  = bus.cmd_addr;
                    wdata_d = bus.cmd_wdata;
                    wstrb_d = bus.cmd_write ? bus.cmd_wstrb : 4'b0000;
                    write_d = bus.cmd_write;
                    req_d   = 1'b1;
                    state_d = BUS;
`ifdef IOMEM_INITIATOR_TIMEOUT_EN
                    wait_d  = '0;
`endif
                end
            end
            BUS: begin
                if (bus.iomem_ready) begin
                    // a write issued with no strobes reads on the bus, but still reports 0
                    rsp_rdata_d = write_q ? 32'h0 : bus.iomem_rdata;
                    rsp_valid_d = 1'b1;
                    req_d       = 1'b0;
                    txn_d       = txn_q + 1'b1;
                    state_d     = RESP;
`ifdef IOMEM_INITIATOR_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
                end else if (wait_q == TIMEOUT_TC) begin
                    rsp_rdata_d = 32'h0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    req_d       = 1'b0;
                    txn_d       = txn_q + 1'b1;
                    state_d     = RESP;
                end else begin
                    wait_d      = wait_q + 16'd1;
`endif
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.cmd_ready   = (state_q == IDLE);
    assign bus.iomem_valid = req_q;
    assign bus.iomem_addr  = addr_q;
    assign bus.iomem_wdata = wdata_q;
    assign bus.iomem_wstrb = wstrb_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
`ifdef IOMEM_INITIATOR_TIMEOUT_EN
    assign bus.rsp_err     = rsp_err_q;
`else
    assign bus.rsp_err     = 1'b0;
`endif
    assign busy            = (state_q != IDLE);
    assign txn_count       = txn_q;
endmodule
